// File: rtl/result_display_pkg.sv
// Purpose: shared seven-segment constants for the board display blocks.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
//
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package result_display_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low digit enables, all digits dark.
    localparam logic [3:0] AN_OFF    = 4'hF;

    // Digit whose decimal point marks the 8.8 binary point.
    localparam logic [1:0] DP_DIGIT  = 2'd2;

    typedef logic [1:0] digit_idx_t;

endpackage

// File: rtl/result_display_hex_to_seg7.sv
// Purpose: nibble to active-low seven-segment hex glyph.
// Latency: combinational, zero cycles.
// Backpressure: none.
//
// Ports: nibble (4-bit value in), seg (7-bit active-low {g,f,e,d,c,b,a} out).
module hex_to_seg7
    import result_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/result_display.sv
// Purpose: hold one 16-bit operator result and scan it in hex on a 4-digit muxed display.
// Latency: captured value reaches the pins two clk edges after the update strobe.
// Backpressure: none; update is a plain strobe, held high it tracks the inputs every cycle.
//
// Ports: clk, rst (async active-high); result/overflow/fixed_mode sampled when update=1;
//        seg/dp/an are registered active-low display pins, an[0] is the rightmost digit.
module result_display
    import result_display_pkg::*;
#(
    parameter int REFRESH_BITS = 18,
    parameter int BLINK_BITS   = 26
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] result,
    input  logic        overflow,
    input  logic        fixed_mode,
    input  logic        update,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an
);

    logic [15:0]             held_val;
    logic                    held_ovf;
    logic                    held_fix;
    logic [REFRESH_BITS-1:0] refresh_cnt;
    logic [BLINK_BITS-1:0]   blink_cnt;
    digit_idx_t              digit_idx;

    logic       refresh_wrap;
    logic [3:0] nibble;
    logic [6:0] digit_seg;
    logic [3:0] an_nxt;
    logic       dp_nxt;

    // Capture registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held_val <= '0;
            held_ovf <= 1'b0;
            held_fix <= 1'b0;
        end else if (update) begin
            held_val <= result;
            held_ovf <= overflow;
            held_fix <= fixed_mode;
        end
    end

    assign refresh_wrap = (refresh_cnt == '1);

    // Refresh and blink counters; the digit index steps once per refresh wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_cnt <= '0;
            blink_cnt   <= '0;
            digit_idx   <= '0;
        end else begin
            refresh_cnt <= refresh_cnt + REFRESH_BITS'(1);
            blink_cnt   <= blink_cnt + BLINK_BITS'(1);
            if (refresh_wrap) begin
                digit_idx <= digit_idx + 2'd1;
            end
        end
    end

    // Nibble select from the held value only, so one output cycle never mixes two values.
    always_comb begin
        nibble = held_val[3:0];
        case (digit_idx)
            2'd0: nibble = held_val[3:0];
            2'd1: nibble = held_val[7:4];
            2'd2: nibble = held_val[11:8];
            2'd3: nibble = held_val[15:12];
            default: nibble = held_val[3:0];
        endcase
    end

    hex_to_seg7 u_hex_to_seg7 (
        .nibble (nibble),
        .seg    (digit_seg)
    );

    // Overflow blink only darkens the anodes; seg/dp keep following the digit.
    always_comb begin
        an_nxt = ~(4'b0001 << digit_idx);
        if (held_ovf && blink_cnt[BLINK_BITS-1]) begin
            an_nxt = AN_OFF;
        end
        dp_nxt = ~(held_fix && (digit_idx == DP_DIGIT));
    end

    // Registered pins, glitch-free toward the board.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg <= SEG_BLANK;
            dp  <= 1'b1;
            an  <= AN_OFF;
        end else begin
            seg <= digit_seg;
            dp  <= dp_nxt;
            an  <= an_nxt;
        end
    end

endmodule

// File: tb/tb_result_display.sv
module tb_result_display;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] result = 16'h0000;
    logic        overflow = 1'b0;
    logic        fixed_mode = 1'b0;
    logic        update = 1'b0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } obs_t;

    obs_t exp_q[$];

    // Reference state of the display, advanced once per clock edge.
    logic [15:0] m_val;
    logic        m_ovf;
    logic        m_fix;
    logic [1:0]  m_rcnt;
    logic [1:0]  m_idx;
    logic [4:0]  m_bcnt;

    result_display #(
        .REFRESH_BITS (2),
        .BLINK_BITS   (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .result     (result),
        .overflow   (overflow),
        .fixed_mode (fixed_mode),
        .update     (update),
        .seg        (seg),
        .dp         (dp),
        .an         (an)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ref_seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Advance one clock edge: compute expected pins from pre-edge state, push, update state.
    task automatic tick();
        obs_t e;
        logic [3:0] nib;
        @(posedge clk);
        if (rst) begin
            m_val = 16'h0; m_ovf = 1'b0; m_fix = 1'b0;
            m_rcnt = 2'd0; m_idx = 2'd0; m_bcnt = 5'd0;
            e = {4'hF, 7'h7F, 1'b1};
        end else begin
            nib = m_val[m_idx*4 +: 4];
            e.an  = (m_ovf && m_bcnt[4]) ? 4'hF : ~(4'b0001 << m_idx);
            e.seg = ref_seg(nib);
            e.dp  = ~(m_fix && (m_idx == 2'd2));
            if (update) begin
                m_val = result; m_ovf = overflow; m_fix = fixed_mode;
            end
            if (m_rcnt == 2'd3) m_idx = m_idx + 2'd1;
            m_rcnt = m_rcnt + 2'd1;
            m_bcnt = m_bcnt + 5'd1;
        end
        exp_q.push_back(e);
        #1;
    endtask

    task automatic test_reset();
        obs_t e;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({an, seg, dp} !== {4'hF, 7'h7F, 1'b1}) begin
            errors++;
            $display("FAIL reset_blank got an=%b seg=%b dp=%b want 1111/1111111/1", an, seg, dp);
        end
        repeat (2) begin
            tick();
            e = exp_q.pop_front();
            checks++;
            if ({an, seg, dp} !== e) begin
                errors++;
                $display("FAIL reset_hold got %b/%b/%b want %b/%b/%b", an, seg, dp, e.an, e.seg, e.dp);
            end
        end
        rst = 1'b0;
        tick();
        e = exp_q.pop_front();
        checks++;
        if ({an, seg, dp} !== {4'b1110, 7'b1000000, 1'b1} || {an, seg, dp} !== e) begin
            errors++;
            $display("FAIL reset_first_scan got an=%b seg=%b dp=%b want 1110/1000000/1", an, seg, dp);
        end
    endtask

    // Scan 1B2A and verify every digit glyph, dp placement and 4-clk dwell.
    task automatic scan_1b2a(input logic fix, input string tag);
        obs_t e;
        int hits[4];
        logic [6:0] want_seg;
        logic want_dp;
        for (int k = 0; k < 4; k++) hits[k] = 0;
        result = 16'h1B2A; overflow = 1'b0; fixed_mode = fix; update = 1'b1;
        tick();
        void'(exp_q.pop_front());
        update = 1'b0;
        repeat (32) begin
            tick();
            e = exp_q.pop_front();
            checks++;
            if ({an, seg, dp} !== e) begin
                errors++;
                $display("FAIL %s_model got %b/%b/%b want %b/%b/%b", tag, an, seg, dp, e.an, e.seg, e.dp);
            end
            want_dp = 1'b1;
            case (an)
                4'b1110: begin want_seg = 7'b0001000; hits[0]++; end
                4'b1101: begin want_seg = 7'b0100100; hits[1]++; end
                4'b1011: begin want_seg = 7'b0000011; hits[2]++; want_dp = ~fix; end
                4'b0111: begin want_seg = 7'b1111001; hits[3]++; end
                default: want_seg = 7'bxxxxxxx;
            endcase
            checks++;
            if (seg !== want_seg || dp !== want_dp) begin
                errors++;
                $display("FAIL %s_digit an=%b got seg=%b dp=%b want seg=%b dp=%b", tag, an, seg, dp, want_seg, want_dp);
            end
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (hits[k] != 8) begin
                errors++;
                $display("FAIL %s_dwell digit %0d got %0d cycles want 8", tag, k, hits[k]);
            end
        end
    endtask

    task automatic test_fixed_scan();
        scan_1b2a(1'b1, "fixed");
    endtask

    task automatic test_float_scan();
        scan_1b2a(1'b0, "float");
    endtask

    task automatic test_overflow_blink();
        obs_t e;
        int blanks;
        result = 16'hFFFF; overflow = 1'b1; fixed_mode = 1'b0; update = 1'b1;
        tick();
        void'(exp_q.pop_front());
        update = 1'b0;
        blanks = 0;
        repeat (32) begin
            tick();
            e = exp_q.pop_front();
            checks++;
            if ({an, seg, dp} !== e) begin
                errors++;
                $display("FAIL blink_model got %b/%b/%b want %b/%b/%b", an, seg, dp, e.an, e.seg, e.dp);
            end
            if (an === 4'hF) blanks++;
            checks++;
            if (seg !== 7'b0001110) begin
                errors++;
                $display("FAIL blink_seg got %b want 0001110", seg);
            end
        end
        checks++;
        if (blanks != 16) begin
            errors++;
            $display("FAIL blink_phase got %0d blank cycles of 32 want 16", blanks);
        end
        overflow = 1'b0; update = 1'b1;
        tick();
        void'(exp_q.pop_front());
        update = 1'b0;
        tick();
        void'(exp_q.pop_front());
        blanks = 0;
        repeat (40) begin
            tick();
            e = exp_q.pop_front();
            checks++;
            if ({an, seg, dp} !== e) begin
                errors++;
                $display("FAIL noblink_model got %b/%b/%b want %b/%b/%b", an, seg, dp, e.an, e.seg, e.dp);
            end
            if (an === 4'hF) blanks++;
        end
        checks++;
        if (blanks != 0) begin
            errors++;
            $display("FAIL noblink got %0d blank cycles want 0", blanks);
        end
    endtask

    task automatic test_midscan_update();
        obs_t e;
        int budget;
        result = 16'h1234; overflow = 1'b0; fixed_mode = 1'b0; update = 1'b1;
        tick();
        void'(exp_q.pop_front());
        update = 1'b0;
        budget = 0;
        while (!(m_idx == 2'd1 && m_rcnt == 2'd0) && budget < 64) begin
            tick();
            e = exp_q.pop_front();
            budget++;
            checks++;
            if ({an, seg, dp} !== e) begin
                errors++;
                $display("FAIL mid_model got %b/%b/%b want %b/%b/%b", an, seg, dp, e.an, e.seg, e.dp);
            end
        end
        checks++;
        if (budget >= 64) begin
            errors++;
            $display("FAIL mid_sync got %0d cycles want <64", budget);
        end
        result = 16'h5678; update = 1'b1;
        tick();
        void'(exp_q.pop_front());
        update = 1'b0;
        checks++;
        if (an !== 4'b1101 || seg !== 7'b0110000) begin
            errors++;
            $display("FAIL mid_old got an=%b seg=%b want 1101/0110000", an, seg);
        end
        tick();
        e = exp_q.pop_front();
        checks++;
        if (an !== 4'b1101 || seg !== 7'b1111000 || {an, seg, dp} !== e) begin
            errors++;
            $display("FAIL mid_new got an=%b seg=%b want 1101/1111000", an, seg);
        end
    endtask

    task automatic test_async_reset();
        obs_t e;
        repeat (5) begin
            tick();
            void'(exp_q.pop_front());
        end
        #3 rst = 1'b1;
        #1;
        checks++;
        if ({an, seg, dp} !== {4'hF, 7'h7F, 1'b1}) begin
            errors++;
            $display("FAIL async_blank got an=%b seg=%b dp=%b want 1111/1111111/1", an, seg, dp);
        end
        tick();
        void'(exp_q.pop_front());
        rst = 1'b0;
        repeat (4) begin
            tick();
            e = exp_q.pop_front();
            checks++;
            if ({an, seg, dp} !== {4'b1110, 7'b1000000, 1'b1} || {an, seg, dp} !== e) begin
                errors++;
                $display("FAIL async_restart got an=%b seg=%b dp=%b want 1110/1000000/1", an, seg, dp);
            end
        end
        tick();
        e = exp_q.pop_front();
        checks++;
        if (an !== 4'b1101 || {an, seg, dp} !== e) begin
            errors++;
            $display("FAIL async_next_digit got an=%b want 1101", an);
        end
    endtask

    initial begin
        test_reset();
        test_fixed_scan();
        test_float_scan();
        test_overflow_blink();
        test_midscan_update();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule
